// File: rtl/bus_arbiter.sv
// Purpose : round-robin arbiter for the shared memory/IO bus; active-low
//           requests in, one registered active-low grant out, with a forced
//           idle turnaround cycle between successive owners.
// Latency : 1 cycle from sampled request to grant; release at edge t drops
//           the grant at t, and the next grant appears at t+1 (one dead cycle).
// Backpressure: none of its own; requesters wait (req_ held low) until granted,
//           and a withdrawn request is simply forgotten.
//
// Ports:
//   clk       bus clock, rising edge
//   reset     synchronous reset, active-high
//   req_      [NREQ] per-requester request, active-low, level
//   gnt_      [NREQ] per-requester grant, active-low, one-hot-low or all-high
//   owner     [3]    index of current/last granted requester (drives bus mux)
//   busy             high while any grant is asserted
//   hold_cnt  [CNT_WIDTH] cycles the current owner has held the grant, saturating
//
// Build option: define BUS_ARB_PREEMPT_EN to preempt an owner that has held
// the bus for MAXHOLD cycles while another requester is waiting.

module bus_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAXHOLD   = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_,
  output logic [NREQ-1:0]      gnt_,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] hold_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_HANDOFF = 2'd2;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  // Elaboration-time parameter sanity checks.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("bus_arbiter: NREQ must be in 2..8");
  end
  if ((MAXHOLD >> CNT_WIDTH) != 0) begin : g_bad_cnt
    $error("bus_arbiter: CNT_WIDTH too narrow for MAXHOLD");
  end

  logic [1:0]           state_q, state_d;
  logic [NREQ-1:0]      gnt_q,   gnt_d;
  logic [2:0]           owner_q, owner_d;
  logic [2:0]           ptr_q,   ptr_d;
  logic                 busy_q,  busy_d;
  logic [CNT_WIDTH-1:0] hold_q,  hold_d;

  // Round-robin search: "hi" collects the lowest requester above the pointer,
  // "lo" the lowest at or below it. Any hi hit wins, so the search order is
  // ptr+1 .. NREQ-1, then 0 .. ptr, and the last owner is considered last.
  logic       hi_vld, lo_vld, win_vld;
  logic [2:0] hi_idx, lo_idx, win_idx;

  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (!req_[i]) begin
        if (3'(i) > ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = 3'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = 3'(i);
        end
      end
    end
  end

  assign win_vld = hi_vld | lo_vld;
  assign win_idx = hi_vld ? hi_idx : lo_idx;

  // The owner is the only requester whose grant bit is low, so masking req_
  // with gnt_q tells us whether the owner still wants the bus without
  // indexing req_ by owner_q.
  logic owner_rel;
  assign owner_rel = &(req_ | gnt_q);

  logic preempt;
`ifdef BUS_ARB_PREEMPT_EN
  logic others_pend;
  assign others_pend = |(~req_ & gnt_q);
  // >= rather than == so a requester that arrives after the counter has
  // saturated still gets the bus at the next edge.
  assign preempt = others_pend && (hold_q >= CNT_WIDTH'(MAXHOLD - 1));
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE, S_HANDOFF: begin
        if (win_vld) begin
          state_d = S_GRANT;
          gnt_d   = ~(ONE_HOT0 << win_idx);
          owner_d = win_idx;
          ptr_d   = win_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (owner_rel || preempt) begin
          state_d = S_HANDOFF;
          gnt_d   = '1;
          busy_d  = 1'b0;
          hold_d  = '0;
        end else if (hold_q != '1) begin
          hold_d  = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '1;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '1;
      owner_q <= '0;
      ptr_q   <= 3'(NREQ - 1);
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_     = gnt_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_ = 4'b1111;
  logic [3:0] gnt_;
  logic [2:0] owner;
  logic       busy;
  logic [4:0] hold_cnt;

  bus_arbiter #(.NREQ(4), .MAXHOLD(16), .CNT_WIDTH(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_     (req_),
    .gnt_     (gnt_),
    .owner    (owner),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [2:0] o;
    logic       b;
    logic [4:0] h;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; the expected outputs after
  // the following rising edge go into the scoreboard.
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] g,
                      input logic [2:0] o, input logic [4:0] h, input string nm);
    exp_t e;
    @(negedge clk);
    reset = r;
    req_  = q;
    e.g = g;
    e.o = o;
    e.b = (g != 4'b1111);
    e.h = h;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: after every rising edge, pop and check any pending expectation.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".gnt"},   8'(gnt_),     8'(e.g));
        chk({nm, ".owner"}, 8'(owner),    8'(e.o));
        chk({nm, ".busy"},  8'(busy),     8'(e.b));
        chk({nm, ".hold"},  8'(hold_cnt), 8'(e.h));
        chk({nm, ".onehot"}, 8'($countones(~gnt_) <= 1), 8'd1);
      end
    end
  end

  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL timeout: stimulus did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [3:0] one;
    logic [3:0] rel;
    one = 4'b0001;

    // Reset with everyone requesting, then first grant to requester 0.
    step(1, 4'b0000, 4'b1111, 3'd0, 5'd0, "rst0");
    step(1, 4'b0000, 4'b1111, 3'd0, 5'd0, "rst1");
    step(0, 4'b0000, 4'b1110, 3'd0, 5'd0, "first_gnt");
    step(0, 4'b1111, 4'b1111, 3'd0, 5'd0, "first_rel");
    step(0, 4'b1111, 4'b1111, 3'd0, 5'd0, "first_idle");

    // Single request from requester 1, held for 5 grant cycles.
    step(0, 4'b1101, 4'b1101, 3'd1, 5'd0, "single_gnt");
    for (int c = 1; c <= 4; c++)
      step(0, 4'b1101, 4'b1101, 3'd1, 5'(c), "single_hold");
    step(0, 4'b1111, 4'b1111, 3'd1, 5'd0, "single_rel");
    step(0, 4'b1111, 4'b1111, 3'd1, 5'd0, "single_idle");

    // Round robin: reset the pointer, then all request; order 0,1,2,3,0.
    step(1, 4'b1111, 4'b1111, 3'd0, 5'd0, "rr_rst");
    step(0, 4'b0000, 4'b1110, 3'd0, 5'd0, "rr_gnt0");
    for (int k = 0; k < 4; k++) begin
      step(0, 4'b0000, ~(one << k), 3'(k), 5'd1, "rr_hold1");
      step(0, 4'b0000, ~(one << k), 3'(k), 5'd2, "rr_hold2");
      rel = one << k;
      step(0, rel, 4'b1111, 3'(k), 5'd0, "rr_dead");
      step(0, 4'b0000, ~(one << ((k + 1) % 4)), 3'((k + 1) % 4), 5'd0, "rr_next");
    end
    step(0, 4'b1111, 4'b1111, 3'd0, 5'd0, "rr_rel");
    step(0, 4'b1111, 4'b1111, 3'd0, 5'd0, "rr_idle");

    // Long hold by requester 0; requester 2 joins from grant cycle 5.
    step(0, 4'b1110, 4'b1110, 3'd0, 5'd0, "hold_gnt");
    for (int c = 1; c <= 15; c++)
      step(0, (c >= 5) ? 4'b1010 : 4'b1110, 4'b1110, 3'd0, 5'(c), "hold_cnt");
`ifdef BUS_ARB_PREEMPT_EN
    step(0, 4'b1010, 4'b1111, 3'd0, 5'd0, "preempt_dead");
    step(0, 4'b1010, 4'b1011, 3'd2, 5'd0, "preempt_gnt2");
`else
    for (int c = 16; c <= 20; c++)
      step(0, 4'b1010, 4'b1110, 3'd0, 5'(c), "no_preempt");
    step(0, 4'b1011, 4'b1111, 3'd0, 5'd0, "hold_rel");
    step(0, 4'b1011, 4'b1011, 3'd2, 5'd0, "hold_gnt2");
`endif
    step(0, 4'b1111, 4'b1111, 3'd2, 5'd0, "hold_rel2");
    step(0, 4'b1111, 4'b1111, 3'd2, 5'd0, "hold_idle");

    // Withdrawn request: req3 low during the grant only, gone by handoff end.
    step(0, 4'b1110, 4'b1110, 3'd0, 5'd0, "wd_gnt0");
    step(0, 4'b0110, 4'b1110, 3'd0, 5'd1, "wd_hold1");
    step(0, 4'b0110, 4'b1110, 3'd0, 5'd2, "wd_hold2");
    step(0, 4'b0111, 4'b1111, 3'd0, 5'd0, "wd_rel");
    step(0, 4'b1111, 4'b1111, 3'd0, 5'd0, "wd_handoff");
    step(0, 4'b1111, 4'b1111, 3'd0, 5'd0, "wd_idle");

    // Reset in the middle of a grant to requester 2 at hold_cnt 7.
    step(0, 4'b1011, 4'b1011, 3'd2, 5'd0, "mr_gnt2");
    for (int c = 1; c <= 7; c++)
      step(0, 4'b1011, 4'b1011, 3'd2, 5'(c), "mr_hold");
    step(1, 4'b1011, 4'b1111, 3'd0, 5'd0, "mr_reset");
    step(0, 4'b1001, 4'b1101, 3'd1, 5'd0, "mr_first");
    step(0, 4'b1011, 4'b1111, 3'd1, 5'd0, "mr_rel");
    step(0, 4'b1011, 4'b1011, 3'd2, 5'd0, "mr_gnt2b");
    step(0, 4'b1111, 4'b1111, 3'd2, 5'd0, "mr_rel2");
    step(0, 4'b1111, 4'b1111, 3'd2, 5'd0, "mr_idle");

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
